// File: rtl/prom_loader.sv
// prom_loader: framed boot loader sitting between the UART receiver and the
// instruction PROM write port. Parses sync, length, little-endian 16-bit
// words and (optionally) an XOR checksum, writes each word to the PROM and
// keeps the CPU in reset until a complete image has been accepted.
//
// Build option: define PROM_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte (length byte XOR all data bytes). Without it the frame ends
// on the last high byte and error code 2 can never occur.
module prom_loader #(
    parameter int         ROM_WORDS     = 16,
    parameter int         ADDR_BITS     = $clog2(ROM_WORDS),
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT_TICKS = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_ready_i,
    output logic                 rx_ack_o,
    input  logic                 reload_i,
    output logic                 prom_we_o,
    output logic [ADDR_BITS-1:0] prom_addr_o,
    output logic [15:0]          prom_data_o,
    output logic                 cpu_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [1:0]           error_code_o
);

    localparam int TO_BITS = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_TICKS - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LENGTH  = 2'd1;
`ifdef PROM_LOADER_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'd2;
`endif
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOW,
        S_HIGH,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] word_idx;
    logic [ADDR_BITS-1:0] last_idx;
    logic [7:0]           low_byte;
    logic [TO_BITS-1:0]   tick_cnt;
`ifdef PROM_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    // Every byte offered by the UART is consumed, whether it is used or dropped.
    assign rx_ack_o = rx_ready_i;

    // A frame is in progress while the parser sits in any in-frame state.
    assign busy_o = (state == S_LEN) || (state == S_LOW) ||
                    (state == S_HIGH) || (state == S_CSUM);

    // Frame parser, PROM write strobe, inter-byte timeout and CPU reset control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cpu_reset_o  <= 1'b1;
            prom_we_o    <= 1'b0;
            prom_addr_o  <= '0;
            prom_data_o  <= '0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            error_code_o <= ERR_NONE;
            word_idx     <= '0;
            last_idx     <= '0;
            low_byte     <= '0;
            tick_cnt     <= '0;
`ifdef PROM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            prom_we_o <= 1'b0;
            if (reload_i) begin
                state        <= S_IDLE;
                cpu_reset_o  <= 1'b1;
                done_o       <= 1'b0;
                error_o      <= 1'b0;
                error_code_o <= ERR_NONE;
                word_idx     <= '0;
                tick_cnt     <= '0;
`ifdef PROM_LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_ready_i && (rx_data_i == SYNC_BYTE)) begin
                            state    <= S_LEN;
                            tick_cnt <= '0;
                        end
                    end

                    S_LEN, S_LOW, S_HIGH, S_CSUM: begin
                        if (rx_ready_i) begin
                            tick_cnt <= '0;
                            if (state == S_LEN) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                                csum <= rx_data_i;
`endif
                                if ((rx_data_i == 8'd0) || (int'(rx_data_i) > ROM_WORDS)) begin
                                    state        <= S_ERROR;
                                    error_o      <= 1'b1;
                                    error_code_o <= ERR_LENGTH;
                                end else begin
                                    last_idx <= ADDR_BITS'(rx_data_i - 8'd1);
                                    word_idx <= '0;
                                    state    <= S_LOW;
                                end
                            end else if (state == S_LOW) begin
                                low_byte <= rx_data_i;
`ifdef PROM_LOADER_CHECKSUM_EN
                                csum     <= csum ^ rx_data_i;
`endif
                                state    <= S_HIGH;
                            end else if (state == S_HIGH) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                                csum        <= csum ^ rx_data_i;
`endif
                                prom_data_o <= {rx_data_i, low_byte};
                                prom_addr_o <= word_idx;
                                prom_we_o   <= 1'b1;
                                if (word_idx == last_idx) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                                    state  <= S_CSUM;
`else
                                    state  <= S_DONE;
                                    done_o <= 1'b1;
`endif
                                end else begin
                                    word_idx <= word_idx + 1'b1;
                                    state    <= S_LOW;
                                end
                            end else begin
`ifdef PROM_LOADER_CHECKSUM_EN
                                if (rx_data_i == csum) begin
                                    state  <= S_DONE;
                                    done_o <= 1'b1;
                                end else begin
                                    state        <= S_ERROR;
                                    error_o      <= 1'b1;
                                    error_code_o <= ERR_CSUM;
                                end
`else
                                state <= S_IDLE;
`endif
                            end
                        end else if (tick_cnt == TO_LAST) begin
                            state        <= S_ERROR;
                            error_o      <= 1'b1;
                            error_code_o <= ERR_TIMEOUT;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        cpu_reset_o <= 1'b0;
                    end

                    S_ERROR: begin
                        cpu_reset_o <= 1'b1;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
